// File: rtl/jtag_uart_pkg.sv
// Shared definitions for the JTAG UART command engine and the JTAG-side logic.
package jtag_uart_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned IR_W    = 4;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned ADDR_W  = 7;

   localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
   localparam logic [STATE_W-1:0] ST_CMD_RD   = 4'd1;
   localparam logic [STATE_W-1:0] ST_CMD_CAP  = 4'd2;
   localparam logic [STATE_W-1:0] ST_DAT_WAIT = 4'd3;
   localparam logic [STATE_W-1:0] ST_DAT_RD   = 4'd4;
   localparam logic [STATE_W-1:0] ST_DAT_CAP  = 4'd5;
   localparam logic [STATE_W-1:0] ST_BUS      = 4'd6;
   localparam logic [STATE_W-1:0] ST_RESP     = 4'd7;
   localparam logic [STATE_W-1:0] ST_RESP_WR  = 4'd8;

   localparam int unsigned CMD_WR_BIT = 7;

   localparam logic [BYTE_W-1:0] ACK_BYTE_DEF = 8'h06;
   localparam logic [BYTE_W-1:0] NAK_BYTE_DEF = 8'h15;

   localparam logic [IR_W-1:0] IR_TX     = 4'h2;
   localparam logic [IR_W-1:0] IR_RX     = 4'h3;
   localparam logic [IR_W-1:0] IR_STATUS = 4'h4;
   localparam logic [IR_W-1:0] IR_BYPASS = 4'hF;

   // Command byte layout as received from the host
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
   } cmd_t;

endpackage

// File: rtl/jtag_uart_cmd.sv
// Pops command bytes from the JTAG UART RX FIFO, runs one register access on
// the local req/ack bus and pushes a one-byte response into the TX FIFO.
module jtag_uart_cmd
   import jtag_uart_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [7:0]  ACK_BYTE = ACK_BYTE_DEF,
   parameter logic [7:0]  NAK_BYTE = NAK_BYTE_DEF
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       uart_rxmt_i,
   input  logic [7:0] uart_data_i,
   output logic       uart_rd_o,
   input  logic       uart_txfl_i,
   output logic       uart_nwr_o,
   output logic [7:0] uart_data_o,
   output logic       bus_req_o,
   output logic       bus_we_o,
   output logic [6:0] bus_addr_o,
   output logic [7:0] bus_wdata_o,
   input  logic [7:0] bus_rdata_i,
   input  logic       bus_ack_i,
   output logic       busy_o,
   output logic [7:0] err_cnt_o
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [STATE_W-1:0] state, state_next;
   cmd_t               cmd, cmd_next;
   logic [7:0]         wdata, wdata_next;
   logic [7:0]         resp, resp_next;
   logic [TW-1:0]      tcnt, tcnt_next;
   logic [1:0]         guard, guard_next;
   logic [7:0]         err_next, data_next;
   logic               rd_next, nwr_next, req_next, we_next, busy_next;
   logic               guard_clr;

   assign bus_addr_o  = cmd.addr;
   assign bus_wdata_o = wdata;
   assign guard_clr   = (guard == 2'd0);

   // Next-state logic; outputs are decoded from the next state and registered
   always_comb begin
      state_next = state;
      cmd_next   = cmd;
      wdata_next = wdata;
      resp_next  = resp;
      tcnt_next  = tcnt;
      err_next   = err_cnt_o;
      // FIFO flags lag one cycle behind each strobe, so hold them off briefly
      guard_next = (uart_rd_o || !uart_nwr_o) ? 2'd2 :
                   (guard_clr ? 2'd0 : guard - 2'd1);

      case (state)
         ST_IDLE:     if (guard_clr && !uart_rxmt_i) state_next = ST_CMD_RD;
         ST_CMD_RD:   state_next = ST_CMD_CAP;
         ST_CMD_CAP: begin
            cmd_next   = cmd_t'(uart_data_i);
            tcnt_next  = '0;
            state_next = uart_data_i[CMD_WR_BIT] ? ST_DAT_WAIT : ST_BUS;
         end
         ST_DAT_WAIT: if (guard_clr && !uart_rxmt_i) state_next = ST_DAT_RD;
         ST_DAT_RD:   state_next = ST_DAT_CAP;
         ST_DAT_CAP: begin
            wdata_next = uart_data_i;
            tcnt_next  = '0;
            state_next = ST_BUS;
         end
         ST_BUS: begin
            // An ack on the final timeout cycle still counts as success
            if (bus_ack_i) begin
               resp_next  = cmd.we ? ACK_BYTE : bus_rdata_i;
               state_next = ST_RESP;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               resp_next  = NAK_BYTE;
               err_next   = (err_cnt_o == 8'hFF) ? err_cnt_o : err_cnt_o + 8'd1;
               state_next = ST_RESP;
            end else begin
               tcnt_next = tcnt + TW'(1);
            end
         end
         ST_RESP:     if (guard_clr && !uart_txfl_i) state_next = ST_RESP_WR;
         ST_RESP_WR:  state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase

      rd_next   = (state_next == ST_CMD_RD) || (state_next == ST_DAT_RD);
      nwr_next  = (state_next != ST_RESP_WR);
      req_next  = (state_next == ST_BUS);
      we_next   = (state_next == ST_BUS) && cmd_next.we;
      busy_next = (state_next != ST_IDLE);
      data_next = (state_next == ST_RESP_WR) ? resp_next : uart_data_o;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= ST_IDLE;
         cmd         <= '0;
         wdata       <= '0;
         resp        <= '0;
         tcnt        <= '0;
         guard       <= '0;
         err_cnt_o   <= '0;
         uart_rd_o   <= 1'b0;
         uart_nwr_o  <= 1'b1;
         uart_data_o <= '0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         state       <= state_next;
         cmd         <= cmd_next;
         wdata       <= wdata_next;
         resp        <= resp_next;
         tcnt        <= tcnt_next;
         guard       <= guard_next;
         err_cnt_o   <= err_next;
         uart_rd_o   <= rd_next;
         uart_nwr_o  <= nwr_next;
         uart_data_o <= data_next;
         bus_req_o   <= req_next;
         bus_we_o    <= we_next;
         busy_o      <= busy_next;
      end
   end

endmodule

// File: tb/tb_jtag_uart_cmd.sv
// Directed bench for jtag_uart_cmd with small RX FIFO, TX FIFO and bus models.
module tb_jtag_uart_cmd;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       uart_rxmt_i = 1'b1;
   logic [7:0] uart_data_i = 8'h00;
   logic       uart_rd_o;
   logic       uart_txfl_i = 1'b0;
   logic       uart_nwr_o;
   logic [7:0] uart_data_o;
   logic       bus_req_o;
   logic       bus_we_o;
   logic [6:0] bus_addr_o;
   logic [7:0] bus_wdata_o;
   logic [7:0] bus_rdata_i = 8'h00;
   logic       bus_ack_i;
   logic       busy_o;
   logic [7:0] err_cnt_o;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   int         rd_q[$];
   int         nwr_q[$];

   int         req_cyc = 0;
   int         last_req_len = 0;
   int         ack_delay = 0;
   bit         ack_en = 1'b1;
   int         push_full = 0;
   int         rd_empty = 0;
   logic       last_we = 1'b0;
   logic [6:0] last_addr = 7'h00;
   logic [7:0] last_wdata = 8'h00;

   always #5 clk = ~clk;

   jtag_uart_cmd #(.TIMEOUT(16)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .uart_rxmt_i (uart_rxmt_i),
      .uart_data_i (uart_data_i),
      .uart_rd_o   (uart_rd_o),
      .uart_txfl_i (uart_txfl_i),
      .uart_nwr_o  (uart_nwr_o),
      .uart_data_o (uart_data_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_rdata_i (bus_rdata_i),
      .bus_ack_i   (bus_ack_i),
      .busy_o      (busy_o),
      .err_cnt_o   (err_cnt_o)
   );

   // Bus slave acks ack_delay cycles into the request (0 = same cycle)
   assign bus_ack_i = ack_en && bus_req_o && (req_cyc == ack_delay);

   // FIFO and bus models; the RX empty flag is one cycle stale
   always @(posedge clk) begin
      cyc <= cyc + 1;
      uart_rxmt_i <= (rx_q.size() == 0);
      if (uart_rd_o) begin
         rd_q.push_back(cyc);
         if (rx_q.size() > 0) uart_data_i <= rx_q.pop_front();
         else rd_empty <= rd_empty + 1;
      end
      if (!uart_nwr_o) begin
         tx_q.push_back(uart_data_o);
         nwr_q.push_back(cyc);
         if (uart_txfl_i) push_full <= push_full + 1;
      end
      if (bus_req_o) begin
         req_cyc <= req_cyc + 1;
         if (bus_ack_i) begin
            last_we    <= bus_we_o;
            last_addr  <= bus_addr_o;
            last_wdata <= bus_wdata_o;
         end
      end else if (req_cyc != 0) begin
         last_req_len <= req_cyc;
         req_cyc <= 0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_rx(input logic [7:0] b);
      @(negedge clk);
      rx_q.push_back(b);
   endtask

   task automatic clear_logs();
      tx_q.delete();
      rd_q.delete();
      nwr_q.delete();
   endtask

   task automatic wait_tx(input int budget, output logic [7:0] b, output bit ok);
      ok = 1'b0;
      b = 8'h00;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [35:0] got;
      reset_i = 1'b1;
      repeat (3) @(negedge clk);
      got = {uart_rd_o, uart_nwr_o, uart_data_o, bus_req_o, bus_we_o,
             bus_addr_o, bus_wdata_o, busy_o, err_cnt_o};
      total++;
      if (got !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00}) begin
         bad++; $display("FAIL reset_outputs: got %h want %h", got, 36'h4_0000_0000);
      end
      total++;
      if (uart_nwr_o !== 1'b1) begin bad++; $display("FAIL reset_nwr: got %b want 1", uart_nwr_o); end
      reset_i = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_read();
      logic [7:0] b; bit ok;
      clear_logs(); ack_en = 1'b1; ack_delay = 2; bus_rdata_i = 8'hA5;
      push_rx(8'h05);
      wait_tx(60, b, ok);
      total++; if (!ok) begin bad++; $display("FAIL read_wait: got no TX byte want one"); end
      total++; if (b !== 8'hA5) begin bad++; $display("FAIL read_data: got %h want a5", b); end
      total++; if (last_we !== 1'b0) begin bad++; $display("FAIL read_we: got %b want 0", last_we); end
      total++; if (last_addr !== 7'h05) begin bad++; $display("FAIL read_addr: got %h want 05", last_addr); end
      repeat (10) @(negedge clk);
      total++; if (nwr_q.size() != 1) begin bad++; $display("FAIL read_tx_count: got %0d want 1", nwr_q.size()); end
      total++; if (err_cnt_o !== 8'h00) begin bad++; $display("FAIL read_err: got %h want 00", err_cnt_o); end
   endtask

   task automatic test_latency();
      logic [7:0] b; bit ok; int lat;
      clear_logs(); ack_en = 1'b1; ack_delay = 0; bus_rdata_i = 8'h3E;
      push_rx(8'h02);
      wait_tx(60, b, ok);
      total++; if (!ok || b !== 8'h3E) begin bad++; $display("FAIL lat_data: got %h want 3e", b); end
      lat = (nwr_q.size() > 0 && rd_q.size() > 0) ? nwr_q[0] - rd_q[0] : -1;
      total++; if (lat != 4) begin bad++; $display("FAIL lat_cycles: got %0d want 4", lat); end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] b0, b1; bit ok0, ok1; int gap;
      clear_logs(); ack_en = 1'b1; ack_delay = 0; bus_rdata_i = 8'h44;
      push_rx(8'h0A);
      push_rx(8'h0B);
      wait_tx(60, b0, ok0);
      wait_tx(60, b1, ok1);
      total++; if (!ok0 || !ok1 || b0 !== 8'h44 || b1 !== 8'h44) begin
         bad++; $display("FAIL b2b_data: got %h %h want 44 44", b0, b1);
      end
      gap = (rd_q.size() > 1 && nwr_q.size() > 0) ? rd_q[1] - nwr_q[0] : -1;
      total++; if (!(gap >= 3)) begin bad++; $display("FAIL b2b_gap: got %0d want >=3", gap); end
      total++; if (last_addr !== 7'h0B) begin bad++; $display("FAIL b2b_addr: got %h want 0b", last_addr); end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_write_split();
      logic [7:0] b; bit ok;
      clear_logs(); ack_en = 1'b1; ack_delay = 0;
      push_rx(8'h83);
      repeat (20) @(negedge clk);
      total++; if (bus_req_o !== 1'b0 || busy_o !== 1'b1) begin
         bad++; $display("FAIL split_wait: got req=%b busy=%b want req=0 busy=1", bus_req_o, busy_o);
      end
      total++; if (rd_q.size() != 1 || tx_q.size() != 0) begin
         bad++; $display("FAIL split_pops: got rd=%0d tx=%0d want rd=1 tx=0", rd_q.size(), tx_q.size());
      end
      push_rx(8'h3C);
      wait_tx(60, b, ok);
      total++; if (!ok || b !== 8'h06) begin bad++; $display("FAIL split_ack: got %h want 06", b); end
      total++; if ({last_we, last_addr, last_wdata} !== {1'b1, 7'h03, 8'h3C}) begin
         bad++; $display("FAIL split_bus: got we=%b addr=%h wd=%h want we=1 addr=03 wd=3c",
                         last_we, last_addr, last_wdata);
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [7:0] b; bit ok; int misses;
      clear_logs(); ack_en = 1'b0;
      push_rx(8'h10);
      wait_tx(80, b, ok);
      total++; if (!ok || b !== 8'h15) begin bad++; $display("FAIL to_nak: got %h want 15", b); end
      total++; if (last_req_len != 16) begin bad++; $display("FAIL to_req_len: got %0d want 16", last_req_len); end
      total++; if (err_cnt_o !== 8'd1) begin bad++; $display("FAIL to_err1: got %0d want 1", err_cnt_o); end
      misses = 0;
      for (int i = 0; i < 299; i++) begin
         push_rx(8'h10);
         wait_tx(80, b, ok);
         if (!ok || b !== 8'h15) misses++;
      end
      total++; if (misses != 0) begin bad++; $display("FAIL to_repeat: got %0d bad responses want 0", misses); end
      total++; if (err_cnt_o !== 8'd255) begin bad++; $display("FAIL to_saturate: got %0d want 255", err_cnt_o); end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [7:0] b; bit ok;
      clear_logs(); ack_en = 1'b1; ack_delay = 0; bus_rdata_i = 8'h5A;
      uart_txfl_i = 1'b1;
      push_rx(8'h01);
      repeat (50) @(negedge clk);
      total++; if (nwr_q.size() != 0 || busy_o !== 1'b1) begin
         bad++; $display("FAIL bp_hold: got pushes=%0d busy=%b want 0 1", nwr_q.size(), busy_o);
      end
      uart_txfl_i = 1'b0;
      wait_tx(20, b, ok);
      total++; if (!ok || b !== 8'h5A) begin bad++; $display("FAIL bp_data: got %h want 5a", b); end
      repeat (10) @(negedge clk);
      total++; if (nwr_q.size() != 1 || push_full != 0) begin
         bad++; $display("FAIL bp_pulses: got %0d full_pushes=%0d want 1 0", nwr_q.size(), push_full);
      end
   endtask

   task automatic test_reset_mid_bus();
      logic [7:0] b; bit ok; bit seen; logic [35:0] got;
      clear_logs(); ack_en = 1'b0;
      push_rx(8'h07);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (bus_req_o) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL rst_req_seen: got no request want one"); end
      reset_i = 1'b1;
      @(negedge clk);
      got = {uart_rd_o, uart_nwr_o, uart_data_o, bus_req_o, bus_we_o,
             bus_addr_o, bus_wdata_o, busy_o, err_cnt_o};
      total++;
      if (got !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00}) begin
         bad++; $display("FAIL rst_mid_outputs: got %h want %h", got, 36'h4_0000_0000);
      end
      reset_i = 1'b0;
      repeat (5) @(negedge clk);
      total++; if (tx_q.size() != 0) begin bad++; $display("FAIL rst_no_resp: got %0d TX bytes want 0", tx_q.size()); end
      ack_en = 1'b1; ack_delay = 1; bus_rdata_i = 8'h77;
      push_rx(8'h01);
      wait_tx(60, b, ok);
      total++; if (!ok || b !== 8'h77) begin bad++; $display("FAIL rst_after_data: got %h want 77", b); end
      total++; if (last_addr !== 7'h01) begin bad++; $display("FAIL rst_after_addr: got %h want 01", last_addr); end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_ack_on_timeout();
      logic [7:0] b; bit ok;
      clear_logs(); ack_en = 1'b1; ack_delay = 15; bus_rdata_i = 8'hC3;
      push_rx(8'h22);
      wait_tx(80, b, ok);
      total++; if (!ok || b !== 8'hC3) begin bad++; $display("FAIL ackto_data: got %h want c3", b); end
      total++; if (err_cnt_o !== 8'h00) begin bad++; $display("FAIL ackto_err: got %0d want 0", err_cnt_o); end
      total++; if (last_req_len != 16) begin bad++; $display("FAIL ackto_len: got %0d want 16", last_req_len); end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_read();
      test_latency();
      test_back_to_back();
      test_write_split();
      test_timeout();
      test_backpressure();
      test_reset_mid_bus();
      test_ack_on_timeout();
      total++; if (rd_empty != 0) begin bad++; $display("FAIL rd_on_empty: got %0d want 0", rd_empty); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
